// File: rtl/reg_strobe_ctrl.sv
// reg_strobe_ctrl -- register-file strobe sequencer for the CPU datapath.
//
// Accepts register-access micro-ops (READ, WRITE, MOVE, NOP) and drives a
// registered one-hot strobe vector R.
//
// Strobe layout (MSB-first interleaved pairs):
//   read strobe of register i  = bit 2*NREG-1-2*i
//   write strobe of register i = bit 2*NREG-2-2*i
//
// Each strobe is held for HOLD cycles. A MOVE is sequenced as a read of the
// source followed directly by a write of the destination.
//
// Optional build macro:
//   REG_STROBE_CHECK_EN  adds the err output. err pulses for one cycle when a
//                        phase targets an index >= NREG, and when a NOP is
//                        accepted with a nonzero req_src.
//
// Handshake: a request is accepted at a rising clk edge where
// req_valid & req_ready. The request fields are captured at that edge, so
// the requester may change them afterwards. req_ready does not depend on
// req_valid. It is high in IDLE and in the final cycle of a request, which
// lets back-to-back requests run with no idle gap.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_op              00 READ, 01 WRITE, 10 MOVE, 11 NOP
//   req_src, req_dst    register indices (req_dst is used only by MOVE)
//   R                   registered one-hot strobe vector (all zero when idle)
//   busy                a request is in progress (PH1/PH2)
//   done                one-cycle pulse in the final cycle of a request
//   err                 (REG_STROBE_CHECK_EN only) index/encoding misuse
//   state_dbg           current FSM state, for observation
module reg_strobe_ctrl #(
  parameter int NREG = 8,
  parameter int HOLD = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [AW-1:0]   req_src,
  input  logic [AW-1:0]   req_dst,
  output logic [2*NREG-1:0] R,
  output logic            busy,
  output logic            done,
`ifdef REG_STROBE_CHECK_EN
  output logic            err,
`endif
  output logic [1:0]      state_dbg
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PH1 = 2'd1, S_PH2 = 2'd2} state_e;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_MOVE = 2'd2, OP_NOP = 2'd3} op_e;

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  op_e           op_q, op_n;
  logic [AW-1:0] dst_q, dst_n;
  logic [2*NREG-1:0] r_q, r_n;
  logic          err_q, err_n;

  logic accept, phase_end, last, load;

  // One-hot strobe for a register index. An index with no matching
  // register (>= NREG) yields all zeros.
  function automatic logic [2*NREG-1:0] strobe(input logic [AW-1:0] idx,
                                               input logic wr);
    logic [2*NREG-1:0] s;
    s = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == AW'(i)) begin
        if (wr) s[2*NREG-2-2*i] = 1'b1;
        else    s[2*NREG-1-2*i] = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic out_of_range(input logic [AW-1:0] idx);
    return ({{(32-AW){1'b0}}, idx} >= 32'(NREG));
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    dst_n   = dst_q;
    r_n     = r_q;
    err_n   = 1'b0;
    load    = 1'b0;

    // A NOP phase lasts one cycle. All other phases last HOLD cycles.
    phase_end = ((state == S_PH1) && ((op_q == OP_NOP) || (cnt == HOLD_LAST))) ||
                ((state == S_PH2) && (cnt == HOLD_LAST));
    // The first phase of a MOVE is not the final cycle of the request.
    last      = phase_end && !((state == S_PH1) && (op_q == OP_MOVE));
    req_ready = (state == S_IDLE) || last;
    accept    = req_valid && req_ready;

    case (state)
      S_IDLE: begin
        if (accept) load = 1'b1;
      end
      default: begin
        if (!phase_end) begin
          cnt_n = cnt + CW'(1);
        end else if (!last) begin
          // MOVE: the write phase starts directly after the read phase.
          state_n = S_PH2;
          cnt_n   = '0;
          r_n     = strobe(dst_q, 1'b1);
          err_n   = out_of_range(dst_q);
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_n = S_IDLE;
          cnt_n   = '0;
          r_n     = '0;
        end
      end
    endcase

    if (load) begin
      state_n = S_PH1;
      cnt_n   = '0;
      op_n    = op_e'(req_op);
      dst_n   = req_dst;
      case (op_e'(req_op))
        OP_READ, OP_MOVE: begin
          r_n   = strobe(req_src, 1'b0);
          err_n = out_of_range(req_src);
        end
        OP_WRITE: begin
          r_n   = strobe(req_src, 1'b1);
          err_n = out_of_range(req_src);
        end
        default: begin
          r_n   = '0;
          err_n = (req_src != '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= OP_NOP;
      dst_q <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      dst_q <= dst_n;
      r_q   <= r_n;
      err_q <= err_n;
    end
  end

  assign R         = r_q;
  assign busy      = (state != S_IDLE);
  assign done      = last;
  assign state_dbg = state;

`ifdef REG_STROBE_CHECK_EN
  assign err = err_q;
`else
  // Without the checker, err_q is computed but unused.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
